// File: rtl/spi.sv
// SPI mode-0 master behind a single-cycle-ack register port: DATA/STATUS/CLKDIV.
// Ack one cycle after an accepted access; busy-time DATA/CLKDIV writes are acked but dropped.
module spi #(
  parameter logic [15:0] DIV_RESET = 16'd4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [3:2]  adr_i,
  input  logic [3:0]  sel_i,
  input  logic        stb_i,
  input  logic        we_i,
  input  logic [31:0] dat_i,
  output logic [31:0] dat_o,
  output logic        ack_o,
  output logic        spiClk_o,
  output logic        spiMosi_o,
  input  logic        spiMiso_i
);

  typedef enum logic {IDLE, XFER} state_t;

  state_t      state, state_nx;
  logic [15:0] clkdiv, hp_cnt;
  logic [3:0]  hp_idx;
  logic [7:0]  tx_sr, rx_sr, rx_byte;
  logic        done, sclk, mosi, ack_q;
  logic [31:0] rd_dat, dat_q;
  logic        accept, wr, rd, busy, start, hp_end, last_hp;
  logic        unused_bits;

  assign busy    = (state == XFER);
  assign accept  = stb_i & ~ack_q;
  assign wr      = accept & we_i;
  assign rd      = accept & ~we_i;
  assign start   = wr & (adr_i == 2'd0) & sel_i[0] & ~busy;
  assign hp_end  = busy & (hp_cnt == clkdiv);
  assign last_hp = hp_end & (hp_idx == 4'd15);

  assign unused_bits = ^{dat_i[31:16], sel_i[3:2]};

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (start)   state_nx = XFER;
      XFER: if (last_hp) state_nx = IDLE;
      default:           state_nx = IDLE;
    endcase
  end

  always_comb begin
    rd_dat = '0;
    unique case (adr_i)
      2'd0:    rd_dat = {24'b0, rx_byte};
      2'd1:    rd_dat = {30'b0, done, busy};
      2'd2:    rd_dat = {16'b0, clkdiv};
      default: rd_dat = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ack_q  <= 1'b0;
      dat_q  <= '0;
      clkdiv <= DIV_RESET;
    end else begin
      ack_q <= accept;
      dat_q <= rd ? rd_dat : '0;
      if (wr && (adr_i == 2'd2) && !busy) begin
        if (sel_i[0]) clkdiv[7:0]  <= dat_i[7:0];
        if (sel_i[1]) clkdiv[15:8] <= dat_i[15:8];
      end
    end
  end

  // Even half-period index ends on a rising SCLK edge (sample), odd on a falling edge (shift).
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      hp_cnt  <= '0;
      hp_idx  <= '0;
      sclk    <= 1'b0;
      mosi    <= 1'b0;
      tx_sr   <= '0;
      rx_sr   <= '0;
      rx_byte <= '0;
      done    <= 1'b0;
    end else begin
      if (rd && (adr_i == 2'd0)) done <= 1'b0;
      if (start) begin
        tx_sr  <= dat_i[7:0];
        mosi   <= dat_i[7];
        sclk   <= 1'b0;
        hp_cnt <= '0;
        hp_idx <= '0;
        rx_sr  <= '0;
        done   <= 1'b0;
      end else if (busy) begin
        if (hp_end) begin
          hp_cnt <= '0;
          hp_idx <= hp_idx + 4'd1;
          if (last_hp) begin
            sclk    <= 1'b0;
            mosi    <= 1'b0;
            rx_byte <= rx_sr;
            done    <= 1'b1;
          end else begin
            sclk <= ~sclk;
            if (!hp_idx[0]) begin
              rx_sr <= {rx_sr[6:0], spiMiso_i};
            end else begin
              tx_sr <= {tx_sr[6:0], 1'b0};
              mosi  <= tx_sr[6];
            end
          end
        end else begin
          hp_cnt <= hp_cnt + 16'd1;
        end
      end
    end
  end

  assign ack_o     = ack_q;
  assign dat_o     = dat_q;
  assign spiClk_o  = sclk;
  assign spiMosi_o = mosi;

endmodule

// File: tb/tb_spi.sv
// Directed bench for spi: register access, mode-0 waveforms, busy timing and reset abort.
module tb_spi;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [3:2]  adr_i;
  logic [3:0]  sel_i;
  logic        stb_i;
  logic        we_i;
  logic [31:0] dat_i;
  logic [31:0] dat_o;
  logic        ack_o;
  logic        spiClk_o;
  logic        spiMosi_o;
  logic        spiMiso_i;
  logic        loop_en;
  logic        miso_val;

  int tests = 0;
  int fails = 0;

  assign spiMiso_i = loop_en ? spiMosi_o : miso_val;

  spi #(.DIV_RESET(16'd4)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .adr_i(adr_i), .sel_i(sel_i), .stb_i(stb_i),
    .we_i(we_i), .dat_i(dat_i), .dat_o(dat_o), .ack_o(ack_o),
    .spiClk_o(spiClk_o), .spiMosi_o(spiMosi_o), .spiMiso_i(spiMiso_i)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge where ack_o is seen.
  task automatic bus_wait(input string tag);
    logic got;
    got = 1'b0;
    for (int n = 0; n < 8 && !got; n++) begin
      @(negedge clk_i);
      got = ack_o;
    end
    stb_i = 1'b0;
    check({tag, "_ack"}, {31'b0, got}, 32'd1);
  endtask

  task automatic bus_write(input string tag, input logic [1:0] a, input logic [3:0] s,
                           input logic [31:0] d);
    stb_i = 1'b1; we_i = 1'b1; adr_i = a; sel_i = s; dat_i = d;
    bus_wait(tag);
  endtask

  task automatic bus_read(input string tag, input logic [1:0] a, input logic [31:0] exp);
    stb_i = 1'b1; we_i = 1'b0; adr_i = a; sel_i = 4'h0; dat_i = '0;
    bus_wait(tag);
    check(tag, dat_o, exp);
  endtask

  initial begin
    logic [7:0] b;
    rst_i = 1'b0; stb_i = 1'b0; we_i = 1'b0; adr_i = 2'd0; sel_i = 4'h0; dat_i = '0;
    loop_en = 1'b0; miso_val = 1'b0;

    // Reset state
    repeat (3) @(negedge clk_i);
    check("rst_ack", {31'b0, ack_o}, 32'd0);
    check("rst_dat", dat_o, 32'd0);
    check("rst_sclk", {31'b0, spiClk_o}, 32'd0);
    check("rst_mosi", {31'b0, spiMosi_o}, 32'd0);
    rst_i = 1'b1;
    @(negedge clk_i);
    bus_read("rst_status", 2'd1, 32'd0);
    @(negedge clk_i);
    check("ack_one_cycle", {31'b0, ack_o}, 32'd0);
    check("dat_zero_idle", dat_o, 32'd0);
    bus_read("rst_clkdiv", 2'd2, 32'd4);
    bus_read("rst_data", 2'd0, 32'd0);

    // Default divider: half-period 5 cycles, MISO tied high
    miso_val = 1'b1;
    b = 8'h3C;
    bus_write("w_3c", 2'd0, 4'b0001, 32'h3C);
    for (int i = 0; i < 80; i++) begin
      if (i > 0) @(negedge clk_i);
      check($sformatf("d4_sclk%0d", i), {31'b0, spiClk_o}, {31'b0, 1'((i / 5) % 2)});
      check($sformatf("d4_mosi%0d", i), {31'b0, spiMosi_o}, {31'b0, b[7 - i / 10]});
    end
    bus_read("d4_busy_last", 2'd1, 32'h1);
    bus_read("d4_done", 2'd1, 32'h2);
    check("d4_idle_sclk", {31'b0, spiClk_o}, 32'd0);
    check("d4_idle_mosi", {31'b0, spiMosi_o}, 32'd0);
    bus_read("d4_rx", 2'd0, 32'hFF);
    bus_read("d4_done_clr", 2'd1, 32'h0);

    // Divider 0, loopback, 0xA5
    bus_write("w_div0", 2'd2, 4'b0011, 32'h0);
    bus_read("div0_rb", 2'd2, 32'h0);
    loop_en = 1'b1;
    b = 8'hA5;
    bus_write("w_a5", 2'd0, 4'b0001, 32'hA5);
    for (int i = 0; i < 16; i++) begin
      if (i > 0) @(negedge clk_i);
      check($sformatf("a5_sclk%0d", i), {31'b0, spiClk_o}, {31'b0, 1'(i % 2)});
      check($sformatf("a5_mosi%0d", i), {31'b0, spiMosi_o}, {31'b0, b[7 - i / 2]});
    end
    bus_read("a5_busy_last", 2'd1, 32'h1);
    bus_read("a5_done", 2'd1, 32'h2);
    bus_read("a5_rx", 2'd0, 32'h000000A5);
    bus_read("a5_done_clr", 2'd1, 32'h0);

    // Writes while busy are acked but dropped
    bus_write("w_11", 2'd0, 4'b0001, 32'h11);
    bus_write("w_22_busy", 2'd0, 4'b0001, 32'h22);
    bus_write("w_div_busy", 2'd2, 4'b0011, 32'h7);
    bus_read("busy_status", 2'd1, 32'h1);
    bus_read("busy_old_rx", 2'd0, 32'hA5);
    repeat (30) @(negedge clk_i);
    bus_read("x11_done", 2'd1, 32'h2);
    bus_read("x11_rx", 2'd0, 32'h11);
    bus_read("x11_div", 2'd2, 32'h0);

    // Byte enables and ignored writes
    bus_write("w_div_sel0", 2'd2, 4'b0001, 32'h1234);
    bus_read("div_sel0", 2'd2, 32'h0034);
    bus_write("w_adr3", 2'd3, 4'b1111, 32'hFFFF_FFFF);
    bus_read("adr3", 2'd3, 32'h0);
    bus_write("w_data_nosel", 2'd0, 4'b0010, 32'hFF);
    bus_read("nosel_status", 2'd1, 32'h0);

    // Reset mid-transfer (half-period 53 cycles)
    loop_en = 1'b0;
    miso_val = 1'b1;
    bus_write("w_ff", 2'd0, 4'b0001, 32'hFF);
    repeat (60) @(negedge clk_i);
    check("mid_sclk_high", {31'b0, spiClk_o}, 32'd1);
    check("mid_mosi_high", {31'b0, spiMosi_o}, 32'd1);
    rst_i = 1'b0;
    #1;
    check("arst_sclk", {31'b0, spiClk_o}, 32'd0);
    check("arst_mosi", {31'b0, spiMosi_o}, 32'd0);
    check("arst_ack", {31'b0, ack_o}, 32'd0);
    check("arst_dat", dat_o, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    bus_read("post_status", 2'd1, 32'h0);
    bus_read("post_rx", 2'd0, 32'h0);
    bus_read("post_div", 2'd2, 32'h4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/spi.md
SPI -- requirements
Module: spi

Interface
REQ-001 SHALL have parameter DIV_RESET, default 16'd4, reset value of the CLKDIV register.
REQ-002 SHALL have port clk_i  input  1  sole clock; all logic is rising-edge.
REQ-003 SHALL have port rst_i  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port adr_i  input  [3:2]  word address of the register.
REQ-005 SHALL have port sel_i  input  4  byte enables for writes.
REQ-006 SHALL have port stb_i  input  1  bus access request.
REQ-007 SHALL have port we_i  input  1  1 = write, 0 = read.
REQ-008 SHALL have port dat_i  input  32  write data.
REQ-009 SHALL have port dat_o  output  32  read data.
REQ-010 SHALL have port ack_o  output  1  access acknowledge.
REQ-011 SHALL have port spiClk_o  output  1  SPI serial clock, mode 0 (idle low).
REQ-012 SHALL have port spiMosi_o  output  1  SPI master-out data.
REQ-013 SHALL have port spiMiso_i  input  1  SPI master-in data.

Function
REQ-014 SHALL accept an access at a clock edge where stb_i=1 and ack_o=0, then drive ack_o=1 for exactly one following cycle.
REQ-015 SHALL hold dat_o valid while ack_o=1 and drive dat_o=0 otherwise.
REQ-016 SHALL apply a write's side effects at the accepting edge.
REQ-017 SHALL decode registers by adr_i as follows.
- adr 0, DATA: write dat_i[7:0] (sel_i[0]=1) = TX byte; read = {24'b0, RX byte}.
- adr 1, STATUS (read-only): bit0 BUSY, bit1 DONE, others 0.
- adr 2, CLKDIV: bits[15:0], byte-enabled by sel_i[1:0]; reads {16'b0, CLKDIV}.
- adr 3: reads 0, writes ignored.
REQ-018 SHALL start a transfer on a DATA write with sel_i[0]=1 while BUSY=0: BUSY<=1, DONE<=0, shift register<=TX byte.
REQ-019 SHALL ignore DATA and CLKDIV writes while BUSY=1; ack_o is still returned.
REQ-020 SHALL transfer 8 bits MSB first in SPI mode 0 (CPOL=0, CPHA=0).
REQ-021 SHALL make each SPI half-period CLKDIV+1 clk_i cycles; CLKDIV=0 gives half-period 1.
REQ-022 SHALL present bit 7 on spiMosi_o from the cycle after the start edge, with spiClk_o low.
REQ-023 SHALL toggle spiClk_o at the end of each half-period: 16 half-periods per byte.
- Rising edges: spiMiso_i is sampled into the RX shift LSB.
- Falling edges 1-7: the next MOSI bit is presented.
REQ-024 SHALL, at the end of the 16th half-period: spiClk_o=0, spiMosi_o=0, RX byte loaded, BUSY<=0, DONE<=1.
REQ-025 SHALL make the total transfer time 16*(CLKDIV+1) clk_i cycles from start to BUSY clearing.
REQ-026 SHALL clear DONE on an accepted DATA read; a DATA read during a transfer returns the previous RX byte.
REQ-027 SHALL let a new transfer start in the cycle after BUSY clears; DONE is cleared by that start.
REQ-028 SHALL drive spiClk_o=0 and spiMosi_o=0 when idle.

Reset
REQ-029 SHALL, while rst_i=0 (asynchronously), force the following values.
- ack_o=0, dat_o=0, spiClk_o=0, spiMosi_o=0.
- BUSY=0, DONE=0, RX=0, CLKDIV=DIV_RESET, half-period counter=0.
REQ-030 SHALL abort any transfer in progress on reset, with no partial RX update.

Verification
REQ-031 SHALL be covered by the following directed scenarios.
- Reset -> STATUS reads 0, CLKDIV reads 4, DATA reads 0, spiClk_o=0, spiMosi_o=0.
- Write CLKDIV=0, write DATA=0xA5, spiMiso_i looped to spiMosi_o -> MOSI bits 1,0,1,0,0,1,0,1; BUSY for 16 cycles; DATA reads 0x000000A5; DONE=1, then DONE=0 after the read.
- Default CLKDIV=4, DATA=0x3C, spiMiso_i tied 1 -> spiClk_o high/low 5 cycles each; BUSY 80 cycles; RX=0xFF.
- Write DATA=0x11 then DATA=0x22 while BUSY -> only 0x11 shifted out; second write acked, no effect.
- CLKDIV write with sel_i=4'b0001, dat_i=0x1234 -> CLKDIV=0x0034.
- rst_i pulsed low mid-transfer -> outputs 0 immediately; STATUS=0 after release; RX unchanged (0).
